regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Arbitrates the decode stage's single register-file write port (write_en / write_id / write_data) between two writeback requesters: the ALU/execute path and the memory/load path. The memory path has fixed priority. An aging counter guarantees the ALU path is never starved. The output is registered and drives the decode-stage write port directly. Writes to x0 are accepted but suppressed.

Parameters:
MAX_WAIT, 4, cycles a valid ALU request may lose arbitration before it is forcibly granted; legal range 1..15
DATA_W, 32, register write data width
ID_W, 5, register index width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle (combinational)
alu_id  input  ID_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load request accepted this cycle (combinational)
mem_id  input  ID_W  load destination register
mem_data  input  DATA_W  load data
write_en  output  1  register-file write enable to decode stage (registered)
write_id  output  ID_W  register-file write index (registered)
write_data  output  DATA_W  register-file write data (registered)
wb_conflict  output  1  both requesters valid this cycle (combinational, stall/perf hint)

Behaviour:
- Reset: rst is sampled on the clk edge and is synchronous, active-high. While rst=1:
  - alu_ready=0 and mem_ready=0; no request is accepted.
  - On the next edge: write_en=0, write_id=0, write_data=0, alu_wait=0.
  - Reset asserted mid-stream discards any un-accepted request; requesters must keep valid asserted to retry after reset.
- Handshake: a transfer occurs when valid&&ready on an edge. A requester holds valid, id and data stable until accepted. ready never depends on the other requester's id or data.
- Grant, evaluated combinationally each cycle with rst=0:
  - If alu_wait==MAX_WAIT and alu_valid: grant ALU.
  - Else if mem_valid: grant MEM.
  - Else if alu_valid: grant ALU.
  - Else: no grant.
  - ready is high only for the granted requester. At most one ready is high per cycle.
- Aging counter alu_wait (4 bits):
  - Increments on each edge where alu_valid=1 and alu_ready=0, saturating at MAX_WAIT.
  - Clears to 0 on an ALU transfer or when alu_valid=0.
  - When the forced grant fires, mem_ready=0 that cycle; MEM waits exactly 1 cycle and is not aged.
- Output register, latency 1 cycle from the transfer edge:
  - write_en = transfer && (granted id != 0).
  - write_id and write_data load the granted request's id and data on every transfer, including x0 transfers.
  - With no transfer: write_en=0; write_id and write_data hold their previous values.
- x0 writes: accepted (ready=1) but write_en stays 0.
- Same-destination collisions: both requesters targeting the same id in one cycle is resolved by the grant rule alone. MEM is written first and ALU one cycle later, unless the forced grant applies.
- Back-to-back: one write per cycle, sustained indefinitely.
- wb_conflict = alu_valid && mem_valid; it is 0 while rst=1.

Optional Feature:
WB_ARB_STATS_EN:
- Defined: adds three 32-bit output ports, each reset to 0 and wrapping modulo 2^32.
  - stat_alu_grants: counts ALU transfers.
  - stat_mem_grants: counts MEM transfers.
  - stat_conflicts: counts cycles with wb_conflict=1.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single MEM request: mem_valid=1, mem_id=7, mem_data=0xDEADBEEF for 1 cycle -> mem_ready=1 that cycle; next cycle write_en=1, write_id=7, write_data=0xDEADBEEF; following cycle write_en=0.
- Contention: alu(id=3, data=0x11) and mem(id=4, data=0x22) both valid from cycle 0 -> MEM written at cycle 1, ALU written at cycle 2; wb_conflict=1 in cycle 0 only.
- Starvation guard, MAX_WAIT=4: mem_valid held high continuously, alu_valid held high -> alu_ready=1 in cycle 4 (mem_ready=0 that cycle); ALU write appears in cycle 5; MEM resumes winning from cycle 5.
- x0 suppression: alu_valid=1, alu_id=0, alu_data=0xFFFFFFFF -> alu_ready=1; next cycle write_en=0 and write_id=0.
- Reset mid-operation: both valid, rst=1 asserted in cycle 2 for 1 cycle -> alu_ready=mem_ready=0 in cycle 2; write_en=0 and alu_wait=0 in cycle 3; arbitration restarts with MEM granted in cycle 3.
- With WB_ARB_STATS_EN: 10 MEM-only transfers, 5 ALU-only transfers, 3 contended cycles -> stat_mem_grants=13, stat_alu_grants=8 (the 3 losing ALU requests drain in later cycles), stat_conflicts=3.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: MEM-priority register-file writeback arbiter with ALU aging guard; WB_ARB_STATS_EN adds grant/conflict counters
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ID_W-1:0]   alu_id,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ID_W-1:0]   mem_id,
    input  logic [DATA_W-1:0] mem_data,
    output logic              write_en,
    output logic [ID_W-1:0]   write_id,
    output logic [DATA_W-1:0] write_data,
`ifdef WB_ARB_STATS_EN
    output logic              wb_conflict,
    output logic [31:0]       stat_alu_grants,
    output logic [31:0]       stat_mem_grants,
    output logic [31:0]       stat_conflicts
`else
    output logic              wb_conflict
`endif
);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
    logic [3:0]        alu_wait_q, alu_wait_d;
    logic              force_alu, xfer;
    logic [ID_W-1:0]   sel_id;
    logic [DATA_W-1:0] sel_data;
    logic              write_en_q;
    logic [ID_W-1:0]   write_id_q;
    logic [DATA_W-1:0] write_data_q;
    always_comb begin
        force_alu   = alu_valid && (alu_wait_q == MAX_W);
        alu_ready   = !rst && alu_valid && (force_alu || !mem_valid);
        mem_ready   = !rst && mem_valid && !force_alu;
        wb_conflict = !rst && alu_valid && mem_valid;
        xfer        = alu_ready || mem_ready;
        sel_id      = alu_ready ? alu_id : mem_id;
        sel_data    = alu_ready ? alu_data : mem_data;
        alu_wait_d  = (!alu_valid || alu_ready) ? 4'd0 :
                      (alu_wait_q == MAX_W) ? MAX_W : alu_wait_q + 4'd1;
    end
    // id/data load even for x0 transfers; only the enable is suppressed
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wait_q   <= '0;
            write_en_q   <= 1'b0;
            write_id_q   <= '0;
            write_data_q <= '0;
        end else begin
            alu_wait_q <= alu_wait_d;
            write_en_q <= xfer && (sel_id != '0);
            if (xfer) begin
                write_id_q   <= sel_id;
                write_data_q <= sel_data;
            end
        end
    end
    assign write_en   = write_en_q;
    assign write_id   = write_id_q;
    assign write_data = write_data_q;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_alu_q, stat_mem_q, stat_cf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_alu_q <= '0;
            stat_mem_q <= '0;
            stat_cf_q  <= '0;
        end else begin
            stat_alu_q <= stat_alu_q + 32'(alu_ready);
            stat_mem_q <= stat_mem_q + 32'(mem_ready);
            stat_cf_q  <= stat_cf_q + 32'(wb_conflict);
        end
    end
    assign stat_alu_grants = stat_alu_q;
    assign stat_mem_grants = stat_mem_q;
    assign stat_conflicts  = stat_cf_q;
`endif
endmodule
